mem_bus_ctrl: RTL and testbench

Multi-cycle memory access controller directly downstream of the TLB/address-translation stage. Takes the MEM-stage request plus translated physical address and chip-select decode (tlb_hit, sram_ce, flash_ce, rom_ce, serial_ce). It sequences the external asynchronous SRAM and a simple peripheral request/acknowledge port. It stalls the pipeline until the access completes.

---
 rtl/mem_bus_ctrl.sv | 271 +++++++++++++++++++++++++++
 tb/tb_mem_bus_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_ctrl.sv
// Multi-cycle memory access controller: async SRAM sequencing plus a req/ack peripheral port.
// Optional peripheral ack timeout is enabled by defining MEM_CTRL_TIMEOUT_EN.
module mem_bus_ctrl #(
    parameter int WAIT_CYCLES    = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [3:0]  sel_i,
    input  logic [31:0] wdata_i,
    input  logic        hold_i,
    input  logic [31:0] addr_i,
    input  logic        tlb_hit_i,
    input  logic        sram_ce_i,
    input  logic        flash_ce_i,
    input  logic        rom_ce_i,
    input  logic        serial_ce_i,
    output logic        stall_o,
    output logic        done_o,
    output logic [31:0] rdata_o,
    output logic        tlb_miss_o,
    output logic        bus_err_o,
    output logic [19:0] sram_addr_o,
    output logic [31:0] sram_wdata_o,
    input  logic [31:0] sram_rdata_i,
    output logic        sram_dout_en_o,
    output logic        sram_ce_n_o,
    output logic        sram_oe_n_o,
    output logic        sram_we_n_o,
    output logic [3:0]  sram_be_n_o,
    output logic        periph_req_o,
    output logic [1:0]  periph_sel_o,
    output logic        periph_we_o,
    output logic [31:0] periph_addr_o,
    output logic [31:0] periph_wdata_o,
    input  logic        periph_ack_i,
    input  logic [31:0] periph_rdata_i
);

    // state    | meaning
    // IDLE     | waiting for an accepted request
    // RD_WAIT  | SRAM read, ce_n/oe_n low for WAIT_CYCLES cycles
    // WR_SETUP | SRAM write, data driven, we_n still high
    // WR_PULSE | SRAM write, we_n low for WAIT_CYCLES cycles
    // WR_HOLD  | SRAM write, we_n high, data still driven
    // PERIPH   | peripheral request outstanding
    // DONE     | one-cycle completion, stall released
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_WAIT  = 3'd1,
        WR_SETUP = 3'd2,
        WR_PULSE = 3'd3,
        WR_HOLD  = 3'd4,
        PERIPH   = 3'd5,
        DONE     = 3'd6
    } state_t;

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

    if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
        $error("mem_bus_ctrl: WAIT_CYCLES must be 1..15");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("mem_bus_ctrl: TIMEOUT_CYCLES must be >= 1");
    end

    state_t      state;
    state_t      state_next;
    logic        accept;
    logic        load_rdata;
    logic [31:0] rdata_next;
    logic        we_q;
    logic        miss_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [1:0]  psel_q;
    logic [19:0] sram_addr_q;
    logic [3:0]  be_n_q;
    logic [31:0] rdata_q;
    logic [3:0]  wait_cnt;
    logic [1:0]  psel_dec;

`ifdef MEM_CTRL_TIMEOUT_EN
    localparam int TMO_W = ($clog2(TIMEOUT_CYCLES) < 8) ? 8 : $clog2(TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES - 1);
    logic [TMO_W-1:0] tmo_cnt;
    logic             set_err;
    logic             err_q;
`endif

    assign accept = (state == IDLE) && req_i && !hold_i;

    always_comb begin
        psel_dec = 2'd0;
        if (serial_ce_i) begin
            psel_dec = 2'd0;
        end else if (flash_ce_i) begin
            psel_dec = 2'd1;
        end else if (rom_ce_i) begin
            psel_dec = 2'd2;
        end
    end

    always_comb begin
        state_next = state;
        load_rdata = 1'b0;
        rdata_next = rdata_q;
`ifdef MEM_CTRL_TIMEOUT_EN
        set_err    = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (accept) begin
                    if (!tlb_hit_i) begin
                        state_next = DONE;
                    end else if (serial_ce_i || flash_ce_i || rom_ce_i) begin
                        state_next = PERIPH;
                    end else if (sram_ce_i) begin
                        state_next = we_i ? WR_SETUP : RD_WAIT;
                    end else begin
                        // Unmapped hit: complete quietly, loads return zero.
                        state_next = DONE;
                        if (!we_i) begin
                            load_rdata = 1'b1;
                            rdata_next = 32'h0;
                        end
                    end
                end
            end
            RD_WAIT: begin
                if (wait_cnt == 4'd0) begin
                    state_next = DONE;
                    load_rdata = 1'b1;
                    rdata_next = sram_rdata_i;
                end
            end
            WR_SETUP: state_next = WR_PULSE;
            WR_PULSE: begin
                if (wait_cnt == 4'd0) begin
                    state_next = WR_HOLD;
                end
            end
            WR_HOLD: state_next = DONE;
            PERIPH: begin
                if (periph_ack_i) begin
                    state_next = DONE;
                    if (!we_q) begin
                        load_rdata = 1'b1;
                        rdata_next = periph_rdata_i;
                    end
`ifdef MEM_CTRL_TIMEOUT_EN
                end else if (tmo_cnt == '0) begin
                    state_next = DONE;
                    set_err    = 1'b1;
                    load_rdata = 1'b1;
                    rdata_next = 32'h0;
`endif
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            we_q        <= 1'b0;
            miss_q      <= 1'b0;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            psel_q      <= 2'd0;
            sram_addr_q <= 20'h0;
            be_n_q      <= 4'hF;
            rdata_q     <= 32'h0;
            wait_cnt    <= 4'd0;
        end else begin
            state <= state_next;
            if (accept) begin
                we_q        <= we_i;
                miss_q      <= !tlb_hit_i;
                addr_q      <= addr_i;
                wdata_q     <= wdata_i;
                psel_q      <= psel_dec;
                sram_addr_q <= addr_i[21:2];
                be_n_q      <= ~sel_i;
            end
            if (load_rdata) begin
                rdata_q <= rdata_next;
            end
            // Preloaded outside the timed states so each timed state starts at terminal-1.
            if (state == RD_WAIT || state == WR_PULSE) begin
                if (wait_cnt != 4'd0) begin
                    wait_cnt <= wait_cnt - 4'd1;
                end
            end else begin
                wait_cnt <= WAIT_LOAD;
            end
        end
    end

`ifdef MEM_CTRL_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            if (state == PERIPH) begin
                if (tmo_cnt != '0) begin
                    tmo_cnt <= tmo_cnt - 1'b1;
                end
            end else begin
                tmo_cnt <= TMO_LOAD;
            end
            if (accept) begin
                err_q <= 1'b0;
            end else if (set_err) begin
                err_q <= 1'b1;
            end
        end
    end

    assign bus_err_o = (state == DONE) && err_q;
`else
    assign bus_err_o = 1'b0;
`endif

    // Strobes decode from state and are forced inactive by rst without waiting for the edge.
    always_comb begin
        stall_o        = 1'b0;
        sram_ce_n_o    = 1'b1;
        sram_oe_n_o    = 1'b1;
        sram_we_n_o    = 1'b1;
        sram_dout_en_o = 1'b0;
        periph_req_o   = 1'b0;
        if (!rst) begin
            stall_o = accept || (state != IDLE && state != DONE);
            case (state)
                RD_WAIT: begin
                    sram_ce_n_o = 1'b0;
                    sram_oe_n_o = 1'b0;
                end
                WR_SETUP, WR_HOLD: begin
                    sram_ce_n_o    = 1'b0;
                    sram_dout_en_o = 1'b1;
                end
                WR_PULSE: begin
                    sram_ce_n_o    = 1'b0;
                    sram_we_n_o    = 1'b0;
                    sram_dout_en_o = 1'b1;
                end
                PERIPH:  periph_req_o = 1'b1;
                default: ;
            endcase
        end
    end

    assign done_o         = (state == DONE);
    assign tlb_miss_o     = (state == DONE) && miss_q;
    assign rdata_o        = rdata_q;
    assign sram_addr_o    = sram_addr_q;
    assign sram_be_n_o    = be_n_q;
    assign sram_wdata_o   = wdata_q;
    assign periph_sel_o   = psel_q;
    assign periph_we_o    = we_q;
    assign periph_addr_o  = addr_q;
    assign periph_wdata_o = wdata_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed self-checking bench for mem_bus_ctrl (WAIT_CYCLES=2, TIMEOUT_CYCLES=8).
// Timeout scenario is exercised when MEM_CTRL_TIMEOUT_EN is defined, indefinite wait otherwise.
module tb_mem_bus_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_i, we_i, hold_i, tlb_hit_i;
    logic        sram_ce_i, flash_ce_i, rom_ce_i, serial_ce_i;
    logic [3:0]  sel_i;
    logic [31:0] wdata_i, addr_i, sram_rdata_i, periph_rdata_i;
    logic        periph_ack_i;
    logic        stall_o, done_o, tlb_miss_o, bus_err_o;
    logic [31:0] rdata_o, sram_wdata_o, periph_addr_o, periph_wdata_o;
    logic [19:0] sram_addr_o;
    logic        sram_dout_en_o, sram_ce_n_o, sram_oe_n_o, sram_we_n_o;
    logic [3:0]  sram_be_n_o;
    logic        periph_req_o, periph_we_o;
    logic [1:0]  periph_sel_o;

    int checks = 0;
    int failures = 0;

    // {ce_n, oe_n, we_n, dout_en, periph_req} and {stall, done, tlb_miss, bus_err}
    logic [4:0] strb;
    logic [3:0] ctl;
    assign strb = {sram_ce_n_o, sram_oe_n_o, sram_we_n_o, sram_dout_en_o, periph_req_o};
    assign ctl  = {stall_o, done_o, tlb_miss_o, bus_err_o};

    localparam logic [4:0] S_IDLE = 5'b11100;
    localparam logic [4:0] S_RD   = 5'b00100;
    localparam logic [4:0] S_WSH  = 5'b01110;
    localparam logic [4:0] S_WP   = 5'b01010;
    localparam logic [4:0] S_PER  = 5'b11101;

    mem_bus_ctrl #(.WAIT_CYCLES(2), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst), .req_i(req_i), .we_i(we_i), .sel_i(sel_i), .wdata_i(wdata_i),
        .hold_i(hold_i), .addr_i(addr_i), .tlb_hit_i(tlb_hit_i), .sram_ce_i(sram_ce_i),
        .flash_ce_i(flash_ce_i), .rom_ce_i(rom_ce_i), .serial_ce_i(serial_ce_i),
        .stall_o(stall_o), .done_o(done_o), .rdata_o(rdata_o), .tlb_miss_o(tlb_miss_o),
        .bus_err_o(bus_err_o), .sram_addr_o(sram_addr_o), .sram_wdata_o(sram_wdata_o),
        .sram_rdata_i(sram_rdata_i), .sram_dout_en_o(sram_dout_en_o), .sram_ce_n_o(sram_ce_n_o),
        .sram_oe_n_o(sram_oe_n_o), .sram_we_n_o(sram_we_n_o), .sram_be_n_o(sram_be_n_o),
        .periph_req_o(periph_req_o), .periph_sel_o(periph_sel_o), .periph_we_o(periph_we_o),
        .periph_addr_o(periph_addr_o), .periph_wdata_o(periph_wdata_o),
        .periph_ack_i(periph_ack_i), .periph_rdata_i(periph_rdata_i)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_i = 1'b0; we_i = 1'b0; hold_i = 1'b0; tlb_hit_i = 1'b0;
        sram_ce_i = 1'b0; flash_ce_i = 1'b0; rom_ce_i = 1'b0; serial_ce_i = 1'b0;
        sel_i = 4'h0; wdata_i = 32'h0; addr_i = 32'h0;
    endtask

    task automatic test_reset();
        rst = 1'b1; idle_inputs(); periph_ack_i = 1'b0;
        sram_rdata_i = 32'h0; periph_rdata_i = 32'h0;
        req_i = 1'b1; tlb_hit_i = 1'b1; sram_ce_i = 1'b1; sel_i = 4'hF;
        for (int i = 0; i < 3; i++) begin
            step(); #1;
            checks++;
            if (strb !== S_IDLE) begin failures++; $display("FAIL reset_strobes: got %b want %b", strb, S_IDLE); end
            checks++;
            if (ctl !== 4'b0000) begin failures++; $display("FAIL reset_ctl: got %b want 0000", ctl); end
        end
        checks++;
        if (rdata_o !== 32'h0) begin failures++; $display("FAIL reset_rdata: got %h want 0", rdata_o); end
        checks++;
        if (sram_be_n_o !== 4'hF) begin failures++; $display("FAIL reset_be_n: got %b want 1111", sram_be_n_o); end
        rst = 1'b0; idle_inputs();
        step();
    endtask

    task automatic test_sram_read();
        req_i = 1'b1; we_i = 1'b0; tlb_hit_i = 1'b1; sram_ce_i = 1'b1; sel_i = 4'hF;
        addr_i = 32'h0000_1234; sram_rdata_i = 32'hDEAD_BEEF;
        #1;
        checks++;
        if (ctl !== 4'b1000) begin failures++; $display("FAIL rd_accept_stall: got %b want 1000", ctl); end
        step();
        idle_inputs(); addr_i = 32'hFFFF_FFFF; we_i = 1'b1;
        #1;
        checks++;
        if (strb !== S_RD) begin failures++; $display("FAIL rd_c1_strobes: got %b want %b", strb, S_RD); end
        checks++;
        if (sram_addr_o !== 20'h0048D) begin failures++; $display("FAIL rd_sram_addr: got %h want 0048d", sram_addr_o); end
        checks++;
        if (sram_be_n_o !== 4'h0) begin failures++; $display("FAIL rd_be_n: got %b want 0000", sram_be_n_o); end
        step(); #1;
        checks++;
        if (strb !== S_RD || ctl !== 4'b1000) begin failures++; $display("FAIL rd_c2: got strb %b ctl %b want %b 1000", strb, ctl, S_RD); end
        step();
        sram_rdata_i = 32'h0;
        #1;
        checks++;
        if (ctl !== 4'b0100 || strb !== S_IDLE) begin failures++; $display("FAIL rd_done: got ctl %b strb %b want 0100 %b", ctl, strb, S_IDLE); end
        checks++;
        if (rdata_o !== 32'hDEAD_BEEF) begin failures++; $display("FAIL rd_rdata: got %h want deadbeef", rdata_o); end
        step(); #1;
        checks++;
        if (ctl !== 4'b0000 || rdata_o !== 32'hDEAD_BEEF) begin failures++; $display("FAIL rd_after: got ctl %b rdata %h want 0000 deadbeef", ctl, rdata_o); end
    endtask

    task automatic test_sram_write();
        req_i = 1'b1; we_i = 1'b1; tlb_hit_i = 1'b1; sram_ce_i = 1'b1; sel_i = 4'b0010;
        wdata_i = 32'h1122_3344; addr_i = 32'h0000_0008;
        #1;
        checks++;
        if (ctl !== 4'b1000) begin failures++; $display("FAIL wr_accept_stall: got %b want 1000", ctl); end
        step();
        idle_inputs(); wdata_i = 32'h5555_AAAA;
        #1;
        checks++;
        if (strb !== S_WSH) begin failures++; $display("FAIL wr_setup: got %b want %b", strb, S_WSH); end
        checks++;
        if (sram_be_n_o !== 4'b1101 || sram_addr_o !== 20'h2) begin failures++; $display("FAIL wr_be_addr: got %b %h want 1101 00002", sram_be_n_o, sram_addr_o); end
        checks++;
        if (sram_wdata_o !== 32'h1122_3344) begin failures++; $display("FAIL wr_wdata: got %h want 11223344", sram_wdata_o); end
        for (int i = 0; i < 2; i++) begin
            step(); #1;
            checks++;
            if (strb !== S_WP) begin failures++; $display("FAIL wr_pulse%0d: got %b want %b", i, strb, S_WP); end
        end
        step(); #1;
        checks++;
        if (strb !== S_WSH || ctl !== 4'b1000) begin failures++; $display("FAIL wr_hold: got strb %b ctl %b want %b 1000", strb, ctl, S_WSH); end
        step(); #1;
        checks++;
        if (ctl !== 4'b0100 || strb !== S_IDLE) begin failures++; $display("FAIL wr_done: got ctl %b strb %b want 0100 %b", ctl, strb, S_IDLE); end
        checks++;
        if (rdata_o !== 32'hDEAD_BEEF) begin failures++; $display("FAIL wr_rdata_held: got %h want deadbeef", rdata_o); end
        step();
    endtask

    task automatic test_tlb_miss();
        req_i = 1'b1; tlb_hit_i = 1'b0; sram_ce_i = 1'b1; serial_ce_i = 1'b1;
        #1;
        checks++;
        if (ctl !== 4'b1000 || strb !== S_IDLE) begin failures++; $display("FAIL miss_accept: got ctl %b strb %b want 1000 %b", ctl, strb, S_IDLE); end
        step();
        idle_inputs();
        #1;
        checks++;
        if (ctl !== 4'b0110 || strb !== S_IDLE) begin failures++; $display("FAIL miss_done: got ctl %b strb %b want 0110 %b", ctl, strb, S_IDLE); end
        step(); #1;
        checks++;
        if (ctl !== 4'b0000) begin failures++; $display("FAIL miss_after: got ctl %b want 0000", ctl); end
    endtask

    task automatic test_no_ce();
        req_i = 1'b1; tlb_hit_i = 1'b1; we_i = 1'b0;
        step();
        idle_inputs();
        #1;
        checks++;
        if (ctl !== 4'b0100 || strb !== S_IDLE || rdata_o !== 32'h0) begin
            failures++; $display("FAIL no_ce_done: got ctl %b strb %b rdata %h want 0100 %b 0", ctl, strb, rdata_o, S_IDLE);
        end
        step();
    endtask

    task automatic test_serial();
        req_i = 1'b1; we_i = 1'b0; tlb_hit_i = 1'b1; serial_ce_i = 1'b1; flash_ce_i = 1'b1; sram_ce_i = 1'b1;
        addr_i = 32'h1000_0004; periph_rdata_i = 32'h0000_0041;
        step();
        idle_inputs();
        for (int i = 1; i <= 4; i++) begin
            #1;
            checks++;
            if (strb !== S_PER || ctl !== 4'b1000) begin failures++; $display("FAIL ser_req%0d: got strb %b ctl %b want %b 1000", i, strb, ctl, S_PER); end
            checks++;
            if (periph_sel_o !== 2'd0 || periph_addr_o !== 32'h1000_0004 || periph_we_o !== 1'b0) begin
                failures++; $display("FAIL ser_attr%0d: got sel %0d addr %h we %b want 0 10000004 0", i, periph_sel_o, periph_addr_o, periph_we_o);
            end
            if (i == 4) periph_ack_i = 1'b1;
            step();
        end
        periph_ack_i = 1'b0;
        #1;
        checks++;
        if (ctl !== 4'b0100 || strb !== S_IDLE || rdata_o !== 32'h41) begin
            failures++; $display("FAIL ser_done: got ctl %b strb %b rdata %h want 0100 %b 41", ctl, strb, rdata_o, S_IDLE);
        end
        step();
    endtask

    task automatic test_periph_sel();
        req_i = 1'b1; we_i = 1'b1; tlb_hit_i = 1'b1; flash_ce_i = 1'b1; rom_ce_i = 1'b1;
        wdata_i = 32'hCAFE_F00D; addr_i = 32'h0000_0020;
        step();
        idle_inputs(); periph_ack_i = 1'b1;
        #1;
        checks++;
        if (periph_sel_o !== 2'd1 || periph_we_o !== 1'b1 || periph_wdata_o !== 32'hCAFE_F00D || strb !== S_PER) begin
            failures++; $display("FAIL flash_attr: got sel %0d we %b wdata %h strb %b want 1 1 cafef00d %b", periph_sel_o, periph_we_o, periph_wdata_o, strb, S_PER);
        end
        step();
        periph_ack_i = 1'b0;
        #1;
        checks++;
        if (ctl !== 4'b0100 || rdata_o !== 32'h41) begin failures++; $display("FAIL flash_done: got ctl %b rdata %h want 0100 41", ctl, rdata_o); end
        step();
        req_i = 1'b1; tlb_hit_i = 1'b1; rom_ce_i = 1'b1; sram_ce_i = 1'b1; periph_rdata_i = 32'h0000_55AA;
        step();
        idle_inputs(); periph_ack_i = 1'b1;
        #1;
        checks++;
        if (periph_sel_o !== 2'd2 || strb !== S_PER) begin failures++; $display("FAIL rom_sel: got sel %0d strb %b want 2 %b", periph_sel_o, strb, S_PER); end
        step();
        periph_ack_i = 1'b0;
        #1;
        checks++;
        if (ctl !== 4'b0100 || rdata_o !== 32'h55AA) begin failures++; $display("FAIL rom_done: got ctl %b rdata %h want 0100 55aa", ctl, rdata_o); end
        step();
    endtask

    task automatic test_periph_wait();
        req_i = 1'b1; tlb_hit_i = 1'b1; serial_ce_i = 1'b1; periph_rdata_i = 32'h0000_0077;
        step();
        idle_inputs();
`ifdef MEM_CTRL_TIMEOUT_EN
        for (int i = 1; i <= 8; i++) begin
            #1;
            checks++;
            if (strb !== S_PER || ctl !== 4'b1000) begin failures++; $display("FAIL tmo_wait%0d: got strb %b ctl %b want %b 1000", i, strb, ctl, S_PER); end
            step();
        end
        #1;
        checks++;
        if (ctl !== 4'b0101 || strb !== S_IDLE || rdata_o !== 32'h0) begin
            failures++; $display("FAIL tmo_done: got ctl %b strb %b rdata %h want 0101 %b 0", ctl, strb, rdata_o, S_IDLE);
        end
        step(); #1;
        checks++;
        if (ctl !== 4'b0000) begin failures++; $display("FAIL tmo_after: got ctl %b want 0000", ctl); end
`else
        for (int i = 1; i <= 20; i++) begin
            #1;
            checks++;
            if (strb !== S_PER || ctl !== 4'b1000) begin failures++; $display("FAIL long_wait%0d: got strb %b ctl %b want %b 1000", i, strb, ctl, S_PER); end
            if (i == 20) periph_ack_i = 1'b1;
            step();
        end
        periph_ack_i = 1'b0;
        #1;
        checks++;
        if (ctl !== 4'b0100 || rdata_o !== 32'h77) begin failures++; $display("FAIL long_done: got ctl %b rdata %h want 0100 77", ctl, rdata_o); end
        step();
`endif
    endtask

    task automatic test_back_to_back();
        req_i = 1'b1; hold_i = 1'b1; tlb_hit_i = 1'b1; sram_ce_i = 1'b1; sel_i = 4'hF;
        sram_rdata_i = 32'h1234_5678;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (ctl !== 4'b0000 || strb !== S_IDLE) begin failures++; $display("FAIL hold_block%0d: got ctl %b strb %b want 0000 %b", i, ctl, strb, S_IDLE); end
            step();
        end
        hold_i = 1'b0;
        #1;
        checks++;
        if (ctl !== 4'b1000) begin failures++; $display("FAIL hold_release: got ctl %b want 1000", ctl); end
        step(); step(); step(); #1;
        checks++;
        if (ctl !== 4'b0100 || rdata_o !== 32'h1234_5678) begin failures++; $display("FAIL b2b_done1: got ctl %b rdata %h want 0100 12345678", ctl, rdata_o); end
        step(); #1;
        checks++;
        if (ctl !== 4'b1000 || strb !== S_IDLE) begin failures++; $display("FAIL b2b_idle: got ctl %b strb %b want 1000 %b", ctl, strb, S_IDLE); end
        step(); #1;
        checks++;
        if (strb !== S_RD) begin failures++; $display("FAIL b2b_second: got strb %b want %b", strb, S_RD); end
        idle_inputs();
        step(); step(); #1;
        checks++;
        if (ctl !== 4'b0100) begin failures++; $display("FAIL b2b_done2: got ctl %b want 0100", ctl); end
        step();
    endtask

    task automatic test_reset_mid();
        req_i = 1'b1; we_i = 1'b1; tlb_hit_i = 1'b1; sram_ce_i = 1'b1; sel_i = 4'hF;
        step();
        idle_inputs();
        step(); #1;
        checks++;
        if (strb !== S_WP) begin failures++; $display("FAIL mid_pulse: got %b want %b", strb, S_WP); end
        rst = 1'b1;
        #1;
        checks++;
        if (strb !== S_IDLE || ctl !== 4'b0000) begin failures++; $display("FAIL mid_release: got strb %b ctl %b want %b 0000", strb, ctl, S_IDLE); end
        step(); #1;
        checks++;
        if (strb !== S_IDLE || ctl !== 4'b0000) begin failures++; $display("FAIL mid_in_reset: got strb %b ctl %b want %b 0000", strb, ctl, S_IDLE); end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(); #1;
            checks++;
            if (strb !== S_IDLE || ctl !== 4'b0000) begin failures++; $display("FAIL mid_after%0d: got strb %b ctl %b want %b 0000", i, strb, ctl, S_IDLE); end
        end
    endtask

    initial begin
        test_reset();
        test_sram_read();
        test_sram_write();
        test_tlb_miss();
        test_no_ce();
        test_serial();
        test_periph_sel();
        test_periph_wait();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
